// File: rtl/npc_ctrl_if.sv
// npc_ctrl_if: memory, decoder and status signals between the sequencer and the core.
interface npc_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        dec_load;
    logic        dec_store;
    logic        dec_ebreak;
    logic        dec_illegal;
    logic        dec_wen;
    logic [31:0] next_pc;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] pc;
    logic        reg_wen;
    logic [31:0] instret;
    logic        halt;
    logic        trap;
    logic [1:0]  trap_cause;
    modport master (
        output imem_req, imem_addr, inst, dmem_req, dmem_we, pc, reg_wen, instret, halt, trap, trap_cause,
        input  imem_rvalid, imem_rdata, dec_load, dec_store, dec_ebreak, dec_illegal, dec_wen, next_pc, dmem_ack
    );
    modport slave (
        input  imem_req, imem_addr, inst, dmem_req, dmem_we, pc, reg_wen, instret, halt, trap, trap_cause,
        output imem_rvalid, imem_rdata, dec_load, dec_store, dec_ebreak, dec_illegal, dec_wen, next_pc, dmem_ack
    );
endinterface

// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle fetch/decode/mem/writeback sequencer owning pc, reg_wen gating and instret.
module npc_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter int          MEM_TIMEOUT = 255
) (
    input logic       clk,
    input logic       rst,
    npc_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, WB, HALT, TRAP} state_t;
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);
    state_t      state;
    logic [31:0] pc, inst, instret;
    logic [7:0]  wcnt;
    logic [1:0]  cause;
    logic        we, wen, bad, reg_wen;
    logic        aligned, timeout;
    assign aligned = bus.next_pc[1:0] == 2'b00;
    assign timeout = wcnt == TO_LAST;
    // Alignment is judged as WB is entered so reg_wen can be a clean register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            instret <= '0;
            wcnt    <= '0;
            cause   <= '0;
            we      <= 1'b0;
            wen     <= 1'b0;
            bad     <= 1'b0;
            reg_wen <= 1'b0;
        end else begin
            reg_wen <= 1'b0;
            wcnt    <= '0;
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (bus.imem_rvalid) begin
                        inst  <= bus.imem_rdata;
                        state <= DECODE;
                    end else if (timeout) begin
                        state <= TRAP;
                        cause <= 2'd3;
                    end else wcnt <= wcnt + 8'd1;
                end
                DECODE: begin
                    we  <= bus.dec_store;
                    wen <= bus.dec_wen & ~bus.dec_store;
                    if (bus.dec_illegal) begin
                        state <= TRAP;
                        cause <= 2'd1;
                    end else if (bus.dec_ebreak) state <= HALT;
                    else if (bus.dec_load | bus.dec_store) state <= MEM;
                    else begin
                        state   <= WB;
                        bad     <= ~aligned;
                        reg_wen <= bus.dec_wen & aligned;
                    end
                end
                MEM: begin
                    if (bus.dmem_ack) begin
                        state   <= WB;
                        bad     <= ~aligned;
                        reg_wen <= wen & aligned;
                    end else if (timeout) begin
                        state <= TRAP;
                        cause <= 2'd3;
                    end else wcnt <= wcnt + 8'd1;
                end
                WB: begin
                    if (bad) begin
                        state <= TRAP;
                        cause <= 2'd2;
                    end else begin
                        pc      <= bus.next_pc;
                        instret <= instret + 32'd1;
                        state   <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.imem_req   = state == FETCH;
    assign bus.imem_addr  = pc;
    assign bus.inst       = inst;
    assign bus.dmem_req   = state == MEM;
    assign bus.dmem_we    = (state == MEM) & we;
    assign bus.pc         = pc;
    assign bus.reg_wen    = reg_wen;
    assign bus.instret    = instret;
    assign bus.halt       = state == HALT;
    assign bus.trap       = state == TRAP;
    assign bus.trap_cause = cause;
endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: randomized instruction streams against a retirement-level model with a scoreboard monitor.
module tb_npc_ctrl;
    localparam int TO = 4;
    localparam logic [31:0] RPC = 32'h8000_0000;
    localparam int ALU = 0, LD = 1, ST = 2, EBRK = 3, ILL = 4, MIS = 5, TOF = 6, TOM = 7, RSTM = 8;
    typedef struct {
        int          kind;
        logic [31:0] pc;
        logic [31:0] instret;
        logic        wrote;
        logic [1:0]  cause;
        int          lat;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    npc_ctrl_if bus();
    npc_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int compared = 0, mismatched = 0;
    exp_t q[$];
    logic [31:0] m_pc, m_ret;
    bit m_first, abort, armed = 1'b0;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", n, act, req);
        end
    endtask
    task automatic wait_req(input bit d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d ? bus.dmem_req : bus.imem_req) begin
                ok = 1'b1;
                return;
            end
        end
        chk(d ? "dmem_req_wait" : "imem_req_wait", 32'd0, 32'd1);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        armed = 1'b1;
        #1;
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        chk("rst_reg_wen", 32'(bus.reg_wen), 32'd0);
        chk("rst_halt_trap", {30'd0, bus.halt, bus.trap}, 32'd0);
        chk("rst_cause", 32'(bus.trap_cause), 32'd0);
        chk("rst_pc", bus.pc, RPC);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        {bus.imem_rvalid, bus.dmem_ack, bus.dec_load, bus.dec_store, bus.dec_ebreak, bus.dec_illegal, bus.dec_wen} = '0;
        bus.imem_rdata = '0;
        bus.next_pc = '0;
        m_pc = RPC;
        m_ret = '0;
        m_first = 1'b1;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask
    task automatic do_instr(input int k, input int fw, input int mw, input logic wen, input logic [31:0] npc);
        exp_t e;
        bit mem, ok, st;
        logic [31:0] w, fpc;
        fpc = m_pc;
        mem = k inside {LD, ST, TOM, RSTM};
        e.lat = (k == TOF) ? TO : 2 + fw + (mem ? (k == TOM ? TO : 1 + mw) : 0) + (k inside {ALU, LD, ST, MIS} ? 1 : 0);
        if (m_first) e.lat++;
        m_first = 1'b0;
        e.pc = m_pc; e.instret = m_ret; e.wrote = 1'b0; e.cause = 2'd0; e.kind = 2;
        if (k inside {ALU, LD, ST}) begin
            m_pc = npc;
            m_ret++;
            e.pc = npc; e.instret = m_ret; e.wrote = wen && k != ST; e.kind = 0;
        end else if (k == EBRK) e.kind = 1;
        else e.cause = (k == ILL) ? 2'd1 : (k == MIS) ? 2'd2 : 2'd3;
        if (k != RSTM) q.push_back(e);
        wait_req(1'b0, ok);
        if (!ok) begin abort = 1'b1; return; end
        chk("imem_addr", bus.imem_addr, fpc);
        if (k == TOF) return;
        bus.imem_rvalid = 1'b0;
        repeat (fw) begin bus.dmem_ack = 1'($urandom); @(negedge clk); end
        st = (k == ST) || ((k == TOM || k == RSTM) && 1'($urandom));
        w = $urandom;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = w; bus.dmem_ack = 1'b0;
        bus.dec_illegal = k == ILL;
        bus.dec_ebreak = k == EBRK || (k == ILL && 1'($urandom));
        bus.dec_store = st;
        bus.dec_load = (mem && !st) || (k inside {ST, ILL, EBRK} && 1'($urandom));
        bus.dec_wen = wen;
        bus.next_pc = npc;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        chk("inst", bus.inst, w);
        if (!mem) return;
        wait_req(1'b1, ok);
        if (!ok) begin abort = 1'b1; return; end
        chk("dmem_we", 32'(bus.dmem_we), 32'(st));
        if (k == TOM || k == RSTM) return;
        repeat (mw) begin bus.imem_rvalid = 1'($urandom); @(negedge clk); end
        bus.imem_rvalid = 1'b0; bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
    endtask
    task automatic finish_run(input int k);
        if (k != RSTM) repeat (20) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        q.delete();
        do_reset();
    endtask
    task automatic run(input int n);
        int k;
        for (int i = 0; i < n && !abort; i++)
            do_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), $urandom & ~32'h3);
        k = $urandom_range(3, 8);
        if (!abort)
            do_instr(k, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                     k == MIS ? (($urandom & ~32'h3) | 32'($urandom_range(1, 3))) : ($urandom & ~32'h3));
        finish_run(k);
    endtask
    // Monitor: an event is a retirement (instret moves) or a halt/trap rising edge.
    int cyc = 0, last_t = 0, ev;
    bit anchor, ph, pt, pw;
    logic [31:0] lr;
    exp_t e;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            anchor = 1'b1; ph = 1'b0; pt = 1'b0; pw = 1'b0; lr = '0;
        end else if (armed) begin
            if (anchor) begin last_t = cyc; anchor = 1'b0; end
            ev = bus.instret != lr ? 0 : (bus.halt && !ph) ? 1 : (bus.trap && !pt) ? 2 : -1;
            if (pw && ev != 0) chk("wen_orphan", bus.instret, lr + 32'd1);
            if (ev >= 0) begin
                if (q.size() == 0) chk("unexpected_event", 32'(ev), 32'hffff_ffff);
                else begin
                    e = q.pop_front();
                    chk("event_kind", 32'(ev), 32'(e.kind));
                    chk("pc", bus.pc, e.pc);
                    chk("instret", bus.instret, e.instret);
                    chk("trap_cause", 32'(bus.trap_cause), 32'(e.cause));
                    chk("reg_wen_pulse", 32'(pw), 32'(e.wrote));
                    chk("latency", 32'(cyc - last_t), 32'(e.lat));
                    last_t = cyc;
                end
            end
            if (bus.halt || bus.trap)
                chk("stopped_outputs", {28'd0, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.reg_wen}, 32'd0);
            ph = bus.halt; pt = bus.trap; pw = bus.reg_wen; lr = bus.instret;
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end
    initial begin
        {bus.imem_rvalid, bus.dmem_ack, bus.dec_load, bus.dec_store, bus.dec_ebreak, bus.dec_illegal, bus.dec_wen} = '0;
        bus.imem_rdata = '0;
        bus.next_pc = '0;
        do_reset();
        repeat (4) do_instr(ALU, 0, 0, 1'b1, m_pc + 32'd4);
        do_instr(EBRK, 0, 0, 1'b0, m_pc);
        finish_run(EBRK);
        repeat (2) do_instr(ALU, 0, 0, 1'b1, m_pc + 32'd4);
        do_instr(EBRK, 0, 0, 1'b0, m_pc);
        finish_run(EBRK);
        do_instr(LD, 0, 2, 1'b1, m_pc + 32'd4);
        do_instr(ST, 0, 0, 1'b1, m_pc + 32'd4);
        do_instr(ILL, 0, 0, 1'b1, m_pc + 32'd4);
        finish_run(ILL);
        do_instr(MIS, 0, 0, 1'b1, 32'h8000_0006);
        finish_run(MIS);
        do_instr(TOF, 0, 0, 1'b0, m_pc);
        finish_run(TOF);
        do_instr(ALU, 1, 0, 1'b1, m_pc + 32'd4);
        do_instr(TOM, 0, 0, 1'b1, m_pc + 32'd4);
        finish_run(TOM);
        do_instr(ALU, 0, 0, 1'b1, m_pc + 32'd4);
        do_instr(RSTM, 0, 0, 1'b1, m_pc + 32'd4);
        finish_run(RSTM);
        repeat (25) run($urandom_range(0, 6));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
